node_mac_seq: RTL and testbench

//  Parametrised, time-multiplexed fixed-point neuron for the ECG classifier layers.

---
 rtl/node_pkg.sv | 24 ++
 rtl/node_mac_seq_if.sv | 38 +++
 rtl/node_act.sv | 51 +++++
 rtl/node_mac_seq.sv | 132 +++++++++++++
 tb/tb_node_mac_seq.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/node_pkg.sv
// Shared types and defaults for the time-multiplexed neuron blocks.
//   state_t      : sequencer states IDLE -> MAC -> ACT -> HOLD
//   ACT_RELU/LIN : activation mode encodings
//   *_D          : default widths used by the interface and the top
package node_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic ACT_RELU = 1'b0;
    localparam logic ACT_LIN  = 1'b1;

    localparam int unsigned N_IN_D  = 10;
    localparam int unsigned DW_D    = 24;
    localparam int unsigned WW_D    = 24;
    localparam int unsigned ACC_W_D = 48;
    localparam int unsigned SHIFT_D = 5;
    localparam int unsigned OUT_W_D = 8;

endpackage

// File: rtl/node_mac_seq_if.sv
// Bus bundle for one neuron: input vector handshake, weight write port and
// result handshake. master = upstream/controller side, slave = neuron side.
//   in_valid/in_ready/in_data/act_mode : input vector handshake
//   w_we/w_addr/w_data/w_drop          : weight/bias write port
//   out_valid/out_ready/out_data       : result handshake
interface node_mac_seq_if
    import node_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_D,
    parameter int unsigned DW    = DW_D,
    parameter int unsigned WW    = WW_D,
    parameter int unsigned OUT_W = OUT_W_D
);
    localparam int unsigned AW = $clog2(N_IN + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [N_IN*DW-1:0]     in_data;
    logic                   act_mode;
    logic                   w_we;
    logic [AW-1:0]          w_addr;
    logic signed [WW-1:0]   w_data;
    logic                   w_drop;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_data;

    modport master (
        output in_valid, in_data, act_mode, w_we, w_addr, w_data, out_ready,
        input  in_ready, w_drop, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, act_mode, w_we, w_addr, w_data, out_ready,
        output in_ready, w_drop, out_valid, out_data
    );

endinterface

// File: rtl/node_act.sv
// Combinational activation / saturation of a signed accumulator.
//   i_acc    : signed accumulator
//   i_mode   : ACT_RELU -> unsigned ReLU with saturation, ACT_LIN -> signed clamp
//   o_data_c : activated OUT_W-bit result (combinational)
module node_act
    import node_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_D,
    parameter int unsigned SHIFT = SHIFT_D,
    parameter int unsigned OUT_W = OUT_W_D
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic                    i_mode,
    output logic [OUT_W-1:0]        o_data_c
);

    // Largest accumulator value representable in the unsigned output window.
    localparam logic signed [ACC_W-1:0] MAXU =
        ACC_W'((64'd1 << (SHIFT + OUT_W)) - 64'd1);
    // Signed output range after the arithmetic shift.
    localparam logic signed [ACC_W-1:0] MAXS =
        ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [ACC_W-1:0] MINS = ~MAXS;

    logic signed [ACC_W-1:0] w_shr;

    assign w_shr = i_acc >>> SHIFT;

    // Select activation; comparisons are full-width so nothing wraps before clamping.
    always_comb begin
        o_data_c = '0;
        if (i_mode == ACT_RELU) begin
            if (i_acc[ACC_W-1]) begin
                o_data_c = '0;
            end else if (i_acc > MAXU) begin
                o_data_c = '1;
            end else begin
                o_data_c = i_acc[SHIFT+OUT_W-1:SHIFT];
            end
        end else begin
            if (w_shr > MAXS) begin
                o_data_c = {1'b0, {(OUT_W-1){1'b1}}};
            end else if (w_shr < MINS) begin
                o_data_c = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                o_data_c = w_shr[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/node_mac_seq.sv
// Time-multiplexed fixed-point neuron: latches an N_IN vector, accumulates
// one product per cycle through a single multiplier starting from the bias,
// then activates and holds the result until accepted.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : node_mac_seq_if.slave (vector in, weight writes, result out)
module node_mac_seq
    import node_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_D,
    parameter int unsigned DW    = DW_D,
    parameter int unsigned WW    = WW_D,
    parameter int unsigned ACC_W = ACC_W_D,
    parameter int unsigned SHIFT = SHIFT_D,
    parameter int unsigned OUT_W = OUT_W_D
) (
    input logic           clk,
    input logic           reset,
    node_mac_seq_if.slave bus
);

    localparam int unsigned AW = $clog2(N_IN + 1);
    localparam int unsigned PW = DW + WW;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [DW-1:0]    r_in [N_IN];
    logic signed [WW-1:0]    r_w  [N_IN+1];
    logic                    r_mode;
    logic signed [ACC_W-1:0] r_acc;
    logic [AW-1:0]           r_idx;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [OUT_W-1:0]        r_out_data;
    logic                    r_w_drop;

    logic                    w_wr_ok;
    logic                    w_last;
    logic signed [WW-1:0]    w_bias;
    logic signed [PW-1:0]    w_prod;
    logic [OUT_W-1:0]        w_act;

    assign w_wr_ok = bus.w_we && (r_state == IDLE) && (bus.w_addr <= AW'(N_IN));
    assign w_last  = (r_idx == AW'(N_IN - 1));

    // A bias write in the handshake cycle must seed the accumulator directly.
    assign w_bias  = (w_wr_ok && (bus.w_addr == AW'(N_IN))) ? bus.w_data : r_w[N_IN];

    assign w_prod  = PW'(r_in[r_idx]) * PW'(r_w[r_idx]);

    node_act #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_act (
        .i_acc    (r_acc),
        .i_mode   (r_mode),
        .o_data_c (w_act)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid)  w_state_nxt = MAC;
            MAC:     if (w_last)        w_state_nxt = ACT;
            ACT:                        w_state_nxt = HOLD;
            HOLD:    if (bus.out_ready) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // Datapath, weight register file and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(N_IN); i++) r_in[i] <= '0;
            for (int i = 0; i <= int'(N_IN); i++) r_w[i] <= '0;
            r_mode      <= ACT_RELU;
            r_acc       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_w_drop    <= 1'b0;
        end else begin
            r_w_drop   <= bus.w_we && !w_wr_ok;
            r_in_ready <= (w_state_nxt == IDLE);
            if (w_wr_ok) begin
                r_w[bus.w_addr] <= bus.w_data;
            end
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < int'(N_IN); i++) begin
                            r_in[i] <= bus.in_data[i*DW +: DW];
                        end
                        r_mode <= bus.act_mode;
                        r_acc  <= ACC_W'(w_bias);
                        r_idx  <= '0;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_idx <= r_idx + AW'(1);
                end
                ACT: begin
                    r_out_data  <= w_act;
                    r_out_valid <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.w_drop    = r_w_drop;

endmodule

// File: tb/tb_node_mac_seq.sv
// Self-checking bench for node_mac_seq: table of vectors with hand-derived
// results, a scoreboard queue of expected outputs, and directed sequences for
// hold, dropped writes, same-cycle write, and mid-vector reset.
module tb_node_mac_seq;
    import node_pkg::*;

    localparam int unsigned N_IN = 10;
    localparam int unsigned DW   = 24;
    localparam int unsigned WW   = 24;
    localparam int unsigned AW   = $clog2(N_IN + 1);
    localparam int unsigned VW   = N_IN * DW;

    typedef struct {
        logic [VW-1:0] data;
        logic          mode;
        logic [7:0]    exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_q [$];
    vec_t tbl [13];
    int   wts [11] = '{-27, -5, -16, -1, -2, -5, -28, 12, -1, -10, -1};

    node_mac_seq_if bus ();

    node_mac_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] one_in(input int idx, input int val);
        logic [VW-1:0] d;
        d = '0;
        d[idx*DW +: DW] = DW'(val);
        return d;
    endfunction

    function automatic logic [VW-1:0] all_in(input int val);
        logic [VW-1:0] d;
        d = '0;
        for (int i = 0; i < int'(N_IN); i++) d[i*DW +: DW] = DW'(val);
        return d;
    endfunction

    task automatic write_w(input int a, input int v, input logic exp_drop);
        bus.w_we   = 1'b1;
        bus.w_addr = AW'(a);
        bus.w_data = WW'(v);
        tick();
        bus.w_we   = 1'b0;
        check($sformatf("w_drop addr%0d", a), 32'(bus.w_drop), 32'(exp_drop));
    endtask

    // Drive one vector, push its expected result, wait for and check the output.
    task automatic run_vec(input string name, input logic [VW-1:0] d, input logic m,
                           input logic [7:0] e, input int hold, input bit mid_wr,
                           input bit wr_hs);
        int n;
        logic [7:0] got;
        logic [7:0] want;
        exp_q.push_back(e);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check({name, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_data  = d;
        bus.act_mode = m;
        bus.in_valid = 1'b1;
        if (wr_hs) begin
            bus.w_we   = 1'b1;
            bus.w_addr = AW'(7);
            bus.w_data = '0;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.w_we     = 1'b0;
        bus.in_data  = '0;
        bus.act_mode = ~m;
        check({name, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
        if (wr_hs) check({name, " w_drop hs"}, 32'(bus.w_drop), 32'd0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            if (mid_wr && n == 2) begin
                bus.w_we   = 1'b1;
                bus.w_addr = AW'(3);
                bus.w_data = WW'(77);
            end else begin
                bus.w_we = 1'b0;
            end
            tick();
            n++;
            if (mid_wr && n == 3) check({name, " w_drop busy"}, 32'(bus.w_drop), 32'd1);
            if (mid_wr && n == 4) check({name, " w_drop pulse"}, 32'(bus.w_drop), 32'd0);
        end
        bus.w_we = 1'b0;
        check({name, " latency"}, 32'(n), 32'(N_IN + 1));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, " hold valid"}, 32'(bus.out_valid), 32'd1);
            check({name, " hold data"}, 32'(bus.out_data), 32'(e));
        end
        got  = bus.out_data;
        want = exp_q.pop_front();
        check({name, " result"}, 32'(got), 32'(want));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, " valid drop"}, 32'(bus.out_valid), 32'd0);
        check({name, " ready again"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int nv;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.act_mode  = ACT_RELU;
        bus.w_we      = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.out_ready = 1'b0;

        tbl[0]  = '{one_in(7, 100),                  ACT_RELU, 8'd37};
        tbl[1]  = '{one_in(7, 1000),                 ACT_RELU, 8'hFF};
        tbl[2]  = '{one_in(7, 683) | one_in(3, 3),   ACT_RELU, 8'hFF}; // acc 8192
        tbl[3]  = '{one_in(7, 683) | one_in(3, 4),   ACT_RELU, 8'hFF}; // acc 8191
        tbl[4]  = '{one_in(7, 681) | one_in(3, 11),  ACT_RELU, 8'hFF}; // acc 8160
        tbl[5]  = '{one_in(7, 681) | one_in(3, 12),  ACT_RELU, 8'hFE}; // acc 8159
        tbl[6]  = '{all_in(32),                      ACT_RELU, 8'h00}; // acc -2657
        tbl[7]  = '{all_in(32),                      ACT_LIN,  8'hAC};
        tbl[8]  = '{one_in(0, 100),                  ACT_LIN,  8'hAB}; // acc -2701
        tbl[9]  = '{one_in(0, 1000),                 ACT_LIN,  8'h80}; // acc -27001
        tbl[10] = '{one_in(7, 1000),                 ACT_LIN,  8'h7F}; // acc 11999
        tbl[11] = '{one_in(7, 100),                  ACT_LIN,  8'h25};
        tbl[12] = '{'0,                              ACT_LIN,  8'hFF}; // bias only

        // Reset state.
        reset = 1'b0;
        tick();
        tick();
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'd0);
        check("rst w_drop", 32'(bus.w_drop), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) write_w(i, wts[i], 1'b0);

        run_vec("t1 hold", tbl[0].data, tbl[0].mode, tbl[0].exp, 3, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].data, tbl[i].mode, tbl[i].exp, 0, 1'b0, 1'b0);
        end

        // Write during MAC is dropped; w3 must still be -1 (acc -101 -> -4).
        run_vec("mac write", one_in(7, 100), ACT_RELU, 8'd37, 0, 1'b1, 1'b0);
        run_vec("w3 kept", one_in(3, 100), ACT_LIN, 8'hFC, 0, 1'b0, 1'b0);
        write_w(11, 5, 1'b1);
        tick();
        check("w_drop one cycle", 32'(bus.w_drop), 32'd0);
        // w7 <= 0 in the handshake cycle is used by that vector: acc = -1.
        run_vec("wr with hs", one_in(7, 100), ACT_RELU, 8'd0, 0, 1'b0, 1'b1);
        write_w(7, 12, 1'b0);
        run_vec("w7 restored", one_in(7, 100), ACT_RELU, 8'd37, 0, 1'b0, 1'b0);

        // Reset mid-MAC aborts the vector and clears the register file.
        bus.in_data  = one_in(7, 100);
        bus.act_mode = ACT_RELU;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("post-rst in_ready", 32'(bus.in_ready), 32'd1);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) nv++;
        end
        check("aborted no output", 32'(nv), 32'd0);
        run_vec("zero w relu", one_in(7, 100), ACT_RELU, 8'd0, 0, 1'b0, 1'b0);
        run_vec("zero w lin", '0, ACT_LIN, 8'd0, 0, 1'b0, 1'b0);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
